// File: rtl/time_set_if.sv
// Signal bundle between the 24h time-set sequencer and its neighbours
// (raw buttons, timekeeper, 7-seg display).
interface time_set_if;
  // There is no back-pressure on this bundle. load is a single-cycle strobe
  // that the timekeeper must accept on that cycle. load_hours and load_minutes
  // are meaningful only while load is high and read 0 otherwise. The button
  // inputs are level signals that may change asynchronously to clk.
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic       run_en;
  logic       load;
  logic [4:0] load_hours;
  logic [5:0] load_minutes;
  logic [4:0] disp_hours;
  logic [5:0] disp_minutes;
  logic [5:0] blank_mask;
  logic [1:0] set_mode;

  modport master (
    output btn_mode, btn_up, btn_down, cur_hours, cur_minutes,
    input  run_en, load, load_hours, load_minutes,
    input  disp_hours, disp_minutes, blank_mask, set_mode
  );

  modport slave (
    input  btn_mode, btn_up, btn_down, cur_hours, cur_minutes,
    output run_en, load, load_hours, load_minutes,
    output disp_hours, disp_minutes, blank_mask, set_mode
  );
endinterface

// File: rtl/time_set_controller.sv
// Button-driven HH:MM editor for the 24h clock. It debounces the buttons, runs
// RUN -> SET_HR -> SET_MIN -> COMMIT, and drives the display value and blink mask.
module time_set_controller #(
  parameter int unsigned DEBOUNCE_CYC     = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYC = 50_000_000,
  parameter int unsigned REPEAT_RATE_CYC  = 10_000_000,
  parameter int unsigned BLINK_HALF_CYC   = 25_000_000,
  parameter int unsigned TIMEOUT_CYC      = 1_000_000_000
) (
  input  logic        clk,
  input  logic        reset,
  time_set_if.slave   bus
);

  localparam int unsigned RP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                   REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int RP_W = $clog2(RP_MAX + 1);
  localparam int BL_W = $clog2(BLINK_HALF_CYC + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RP_W-1:0] RP_DELAY = RP_W'(REPEAT_DELAY_CYC);
  localparam logic [RP_W-1:0] RP_RATE  = RP_W'(REPEAT_RATE_CYC);
  localparam logic [BL_W-1:0] BL_LAST  = BL_W'(BLINK_HALF_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10,
    COMMIT  = 2'b11
  } state_t;

  // Button index: 0 = mode, 1 = up, 2 = down.
  logic [2:0]      raw;
  logic [2:0]      sync1;
  logic [2:0]      sync2;
  logic [2:0]      level;
  logic [2:0]      press;
  logic [DB_W-1:0] db_cnt [0:2];

  logic [RP_W-1:0] rpt_cnt [0:1];
  logic [1:0]      rpt_first;
  logic [1:0]      rpt;

  state_t          state;
  state_t          state_next;
  logic [4:0]      edit_h;
  logic [4:0]      edit_h_next;
  logic [5:0]      edit_m;
  logic [5:0]      edit_m_next;
  logic [TO_W-1:0] idle_cnt;
  logic [BL_W-1:0] blink_cnt;
  logic            phase;

  logic in_set;
  logic mode_press;
  logic up_step;
  logic down_step;
  logic any_act;
  logic timeout;

  assign raw = {bus.btn_down, bus.btn_up, bus.btn_mode};

  // The level flips only after the synchronised input disagrees with it for
  // DEBOUNCE_CYC cycles in a row. The press pulse is issued on that same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      press <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= '0;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          level[i]  <= sync2[i];
          press[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign in_set = (state == SET_HR) || (state == SET_MIN);

  // The repeat counter counts cycles since the press, or since the last
  // repeat step. It restarts at 1 on each repeat, so the next compare is
  // exactly RATE cycles later.
  always_comb begin
    rpt = '0;
    for (int j = 0; j < 2; j++) begin
      rpt[j] = in_set && level[j+1] &&
               (rpt_first[j] ? (rpt_cnt[j] == RP_DELAY) : (rpt_cnt[j] == RP_RATE));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_first <= 2'b11;
      for (int j = 0; j < 2; j++) rpt_cnt[j] <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (!in_set || !level[j+1]) begin
          rpt_cnt[j]   <= '0;
          rpt_first[j] <= 1'b1;
        end else if (rpt[j]) begin
          rpt_cnt[j]   <= RP_W'(1);
          rpt_first[j] <= 1'b0;
        end else begin
          rpt_cnt[j]   <= rpt_cnt[j] + RP_W'(1);
        end
      end
    end
  end

  assign mode_press = press[0];
  assign up_step    = press[1] | rpt[0];
  assign down_step  = press[2] | rpt[1];
  assign any_act    = (|press) | up_step | down_step;
  assign timeout    = in_set && !any_act && (idle_cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      edit_h <= '0;
      edit_m <= '0;
    end else begin
      state  <= state_next;
      edit_h <= edit_h_next;
      edit_m <= edit_m_next;
    end
  end

  // A mode press takes priority over any step in the same cycle. Opposing
  // steps in the same cycle cancel each other.
  always_comb begin
    state_next  = state;
    edit_h_next = edit_h;
    edit_m_next = edit_m;
    case (state)
      RUN: begin
        if (mode_press) begin
          state_next  = SET_HR;
          edit_h_next = bus.cur_hours;
          edit_m_next = bus.cur_minutes;
        end
      end
      SET_HR: begin
        if (mode_press)                  state_next = SET_MIN;
        else if (timeout)                state_next = RUN;
        else if (up_step && !down_step)  edit_h_next = (edit_h == 5'd23) ? 5'd0 : edit_h + 5'd1;
        else if (down_step && !up_step)  edit_h_next = (edit_h == 5'd0) ? 5'd23 : edit_h - 5'd1;
      end
      SET_MIN: begin
        if (mode_press)                  state_next = COMMIT;
        else if (timeout)                state_next = RUN;
        else if (up_step && !down_step)  edit_m_next = (edit_m == 6'd59) ? 6'd0 : edit_m + 6'd1;
        else if (down_step && !up_step)  edit_m_next = (edit_m == 6'd0) ? 6'd59 : edit_m - 6'd1;
      end
      COMMIT:  state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // The idle and blink timers restart on entry to each edit state. They
  // also restart on every user action.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      if (!in_set || (state_next != state) || any_act) idle_cnt <= '0;
      else                                             idle_cnt <= idle_cnt + TO_W'(1);

      if (!in_set || (state_next != state) || up_step || down_step) begin
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if (blink_cnt == BL_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BL_W'(1);
      end
    end
  end

  assign bus.run_en       = (state == RUN);
  assign bus.load         = (state == COMMIT);
  assign bus.load_hours   = (state == COMMIT) ? edit_h : 5'd0;
  assign bus.load_minutes = (state == COMMIT) ? edit_m : 6'd0;
  assign bus.disp_hours   = (state == RUN) ? bus.cur_hours : edit_h;
  assign bus.disp_minutes = (state == RUN) ? bus.cur_minutes : edit_m;
  assign bus.blank_mask   = !phase             ? 6'b000000 :
                            (state == SET_HR)  ? 6'b110000 :
                            (state == SET_MIN) ? 6'b001100 : 6'b000000;
  assign bus.set_mode     = state;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller, run with short debounce, repeat,
// blink and timeout settings.
module tb_time_set_controller;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   load_cnt;
  int   lc;

  time_set_if bus ();

  time_set_controller #(
    .DEBOUNCE_CYC     (4),
    .REPEAT_DELAY_CYC (20),
    .REPEAT_RATE_CYC  (5),
    .BLINK_HALF_CYC   (8),
    .TIMEOUT_CYC      (100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.load) load_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Effects of a press appear 7 cycles after the raw edge (2 sync, 4 debounce, 1 FSM).
  task automatic hold(input logic m, input logic u, input logic d);
    bus.btn_mode = m;
    bus.btn_up   = u;
    bus.btn_down = d;
    wait_cyc(7);
  endtask

  task automatic release_btns();
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    wait_cyc(9);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    load_cnt = 0;
    reset = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    bus.cur_hours = 5'd12;
    bus.cur_minutes = 6'd34;
    wait_cyc(3);
    check("rst_mode", 32'(bus.set_mode), 0);
    check("rst_run_en", 32'(bus.run_en), 1);
    check("rst_load", 32'(bus.load), 0);
    check("rst_load_h", 32'(bus.load_hours), 0);
    check("rst_load_m", 32'(bus.load_minutes), 0);
    check("rst_mask", 32'(bus.blank_mask), 0);
    check("rst_disp_h", 32'(bus.disp_hours), 12);
    reset = 1'b1;
    wait_cyc(2);

    // 1: bouncing mode button, then held high
    for (int i = 0; i < 12; i++) begin
      bus.btn_mode = ((i / 2) % 2) == 0;
      wait_cyc(1);
    end
    check("bounce_none", 32'(bus.set_mode), 0);
    bus.btn_mode = 1'b1;
    wait_cyc(6);
    check("bounce_early", 32'(bus.set_mode), 0);
    wait_cyc(1);
    check("bounce_mode", 32'(bus.set_mode), 1);
    check("bounce_run_en", 32'(bus.run_en), 0);
    wait_cyc(10);
    check("bounce_once", 32'(bus.set_mode), 1);
    release_btns();
    hold(1, 0, 0); release_btns();
    hold(1, 0, 0);
    check("bounce_commit", 32'(bus.set_mode), 3);
    release_btns();
    check("bounce_back_run", 32'(bus.set_mode), 0);

    // 2: full edit from 23:58
    bus.cur_hours = 5'd23;
    bus.cur_minutes = 6'd58;
    hold(1, 0, 0);
    bus.cur_minutes = 6'd59;
    check("e_mode", 32'(bus.set_mode), 1);
    check("e_disp_h", 32'(bus.disp_hours), 23);
    check("e_disp_m_frozen", 32'(bus.disp_minutes), 58);
    release_btns();
    hold(0, 1, 0);
    check("e_hr_wrap_up", 32'(bus.disp_hours), 0);
    release_btns();
    hold(1, 0, 0);
    check("e_set_min", 32'(bus.set_mode), 2);
    release_btns();
    for (int i = 0; i < 3; i++) begin
      hold(0, 0, 1);
      release_btns();
    end
    check("e_min_dn3", 32'(bus.disp_minutes), 55);
    lc = load_cnt;
    hold(1, 0, 0);
    check("e_load", 32'(bus.load), 1);
    check("e_load_h", 32'(bus.load_hours), 0);
    check("e_load_m", 32'(bus.load_minutes), 55);
    check("e_commit", 32'(bus.set_mode), 3);
    check("e_commit_run_en", 32'(bus.run_en), 0);
    wait_cyc(1);
    check("e_run", 32'(bus.set_mode), 0);
    check("e_run_en", 32'(bus.run_en), 1);
    check("e_load_off", 32'(bus.load), 0);
    release_btns();
    check("e_one_strobe", 32'(load_cnt - lc), 1);

    // 4: wrap at zero
    bus.cur_hours = 5'd0;
    bus.cur_minutes = 6'd0;
    hold(1, 0, 0); release_btns();
    hold(0, 0, 1);
    check("w_hr_dn", 32'(bus.disp_hours), 23);
    release_btns();
    hold(0, 1, 0);
    check("w_hr_up", 32'(bus.disp_hours), 0);
    release_btns();
    hold(1, 0, 0); release_btns();
    hold(0, 0, 1);
    check("w_min_dn", 32'(bus.disp_minutes), 59);
    release_btns();
    hold(1, 0, 0);
    check("w_load_h", 32'(bus.load_hours), 0);
    check("w_load_m", 32'(bus.load_minutes), 59);
    release_btns();

    // 5: simultaneous buttons
    bus.cur_hours = 5'd5;
    bus.cur_minutes = 6'd30;
    hold(1, 0, 0); release_btns();
    hold(0, 1, 1);
    check("s_updn_h", 32'(bus.disp_hours), 5);
    check("s_updn_mode", 32'(bus.set_mode), 1);
    release_btns();
    hold(1, 1, 0);
    check("s_modeup_mode", 32'(bus.set_mode), 2);
    check("s_modeup_h", 32'(bus.disp_hours), 5);
    check("s_modeup_m", 32'(bus.disp_minutes), 30);
    release_btns();
    hold(1, 0, 0); release_btns();

    // 3: auto-repeat while holding up in SET_MIN
    bus.cur_hours = 5'd7;
    bus.cur_minutes = 6'd10;
    hold(1, 0, 0); release_btns();
    hold(1, 0, 0); release_btns();
    bus.btn_up = 1'b1;
    wait_cyc(38);
    check("r_mid", 32'(bus.disp_minutes), 14);
    bus.btn_up = 1'b0;
    wait_cyc(12);
    check("r_final", 32'(bus.disp_minutes), 15);
    hold(1, 0, 0);
    check("r_load_h", 32'(bus.load_hours), 7);
    check("r_load_m", 32'(bus.load_minutes), 15);
    release_btns();

    // 6a: blink and idle timeout in SET_HR
    bus.cur_hours = 5'd9;
    bus.cur_minutes = 6'd45;
    lc = load_cnt;
    bus.btn_mode = 1'b1;
    wait_cyc(7);
    check("t_enter", 32'(bus.set_mode), 1);
    bus.btn_mode = 1'b0;
    wait_cyc(7);
    check("t_blink_on", 32'(bus.blank_mask), 0);
    wait_cyc(1);
    check("t_blink_off", 32'(bus.blank_mask), 6'b110000);
    wait_cyc(8);
    check("t_blink_back", 32'(bus.blank_mask), 0);
    wait_cyc(83);
    check("t_before", 32'(bus.set_mode), 1);
    wait_cyc(1);
    check("t_after", 32'(bus.set_mode), 0);
    check("t_run_en", 32'(bus.run_en), 1);
    check("t_no_load", 32'(load_cnt - lc), 0);
    wait_cyc(4);

    // 6b: async reset while in SET_MIN
    bus.cur_hours = 5'd14;
    bus.cur_minutes = 6'd20;
    hold(1, 0, 0); release_btns();
    bus.btn_mode = 1'b1;
    wait_cyc(7);
    check("x_set_min", 32'(bus.set_mode), 2);
    bus.btn_mode = 1'b0;
    wait_cyc(8);
    check("x_blink_min", 32'(bus.blank_mask), 6'b001100);
    #2 reset = 1'b0;
    #1;
    check("x_mode", 32'(bus.set_mode), 0);
    check("x_run_en", 32'(bus.run_en), 1);
    check("x_load", 32'(bus.load), 0);
    check("x_mask", 32'(bus.blank_mask), 0);
    check("x_disp_h", 32'(bus.disp_hours), 14);
    @(negedge clk);
    reset = 1'b1;
    wait_cyc(3);
    check("x_no_load", 32'(load_cnt - lc), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
